// File: rtl/ni_packetizer_if.sv
// Bundle of the request, payload and flit handshakes of the NI packetizer.
// The slave modport is the packetizer's view; the master modport is the
// view of whoever drives requests/payload and sinks flits.
interface ni_packetizer_if #(
   parameter int PACKET_ADDR_COL_W = 4,
   parameter int PACKET_ADDR_ROW_W = 4,
   parameter int FLIT_DATA_W       = 8,
   parameter int LEN_W             = 4
);

   logic                          req_valid_i;
   logic                          req_ready_o;
   logic [PACKET_ADDR_COL_W-1:0]  req_col_addr_i;
   logic [PACKET_ADDR_ROW_W-1:0]  req_row_addr_i;
   logic [LEN_W-1:0]              req_len_i;
   logic                          data_valid_i;
   logic                          data_ready_o;
   logic [FLIT_DATA_W-1:0]        data_i;
   logic                          flit_valid_o;
   logic                          flit_ready_i;
   logic [FLIT_DATA_W+1:0]        flit_o;
   logic                          busy_o;

   modport slave (
      input  req_valid_i,
      input  req_col_addr_i,
      input  req_row_addr_i,
      input  req_len_i,
      input  data_valid_i,
      input  data_i,
      input  flit_ready_i,
      output req_ready_o,
      output data_ready_o,
      output flit_valid_o,
      output flit_o,
      output busy_o
   );

   modport master (
      output req_valid_i,
      output req_col_addr_i,
      output req_row_addr_i,
      output req_len_i,
      output data_valid_i,
      output data_i,
      output flit_ready_i,
      input  req_ready_o,
      input  data_ready_o,
      input  flit_valid_o,
      input  flit_o,
      input  busy_o
   );

endinterface

// File: rtl/ni_packetizer.sv
// Resource-side NI transmitter for the XY mesh. A send request becomes a
// HEAD flit carrying {row, col} (col in the LSBs), followed by one flit per
// payload word with the last one marked TAIL; a zero-length request becomes
// a single HEAD_TAIL flit. Flits sit in one output register that is held
// stable until the router takes them.
//
// Optional feature, macro NI_SELF_ADDR_DROP_EN: requests addressed to this
// node (COL_CORD, ROW_CORD) are accepted and their payload drained, but no
// flit is emitted; drop_o pulses for one cycle after such an accept.
module ni_packetizer #(
   parameter logic [3:0] COL_CORD          = 4'd0,
   parameter logic [3:0] ROW_CORD          = 4'd0,
   parameter int         PACKET_ADDR_COL_W = 4,
   parameter int         PACKET_ADDR_ROW_W = 4,
   parameter int         FLIT_DATA_W       = 8,
   parameter int         LEN_W             = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
`ifdef NI_SELF_ADDR_DROP_EN
   output logic           drop_o,
`endif
   ni_packetizer_if.slave bus
);

   localparam int FLIT_W = FLIT_DATA_W + 2;

   localparam logic [1:0] TYPE_BODY      = 2'b00;
   localparam logic [1:0] TYPE_HEAD      = 2'b01;
   localparam logic [1:0] TYPE_TAIL      = 2'b10;
   localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

   typedef enum logic {
      IDLE,
      BODY
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [LEN_W-1:0]        remaining_q;
   logic [LEN_W-1:0]        remaining_d;
   logic                    flit_valid_q;
   logic [FLIT_W-1:0]       flit_q;
   logic [FLIT_W-1:0]       flit_d;
   logic                    load_flit;
   logic                    out_free;
   logic                    req_ready;
   logic                    data_ready;
   logic                    req_fire;
   logic                    data_fire;
   logic [FLIT_DATA_W-1:0]  header_data;

   // Parameter sanity: the header must fit in a flit and the node's own
   // coordinates must be representable in the address fields.
   if ((32'(COL_CORD) >= (1 << PACKET_ADDR_COL_W)) ||
       (32'(ROW_CORD) >= (1 << PACKET_ADDR_ROW_W)) ||
       (FLIT_DATA_W < PACKET_ADDR_COL_W + PACKET_ADDR_ROW_W)) begin : g_param_check
      $error("ni_packetizer: inconsistent address/flit parameters");
   end

`ifdef NI_SELF_ADDR_DROP_EN
   localparam logic [PACKET_ADDR_COL_W-1:0] SELF_COL = PACKET_ADDR_COL_W'(COL_CORD);
   localparam logic [PACKET_ADDR_ROW_W-1:0] SELF_ROW = PACKET_ADDR_ROW_W'(ROW_CORD);

   logic self_hit;
   logic drop_fire;
   logic drop_mode_q;
   logic drop_mode_d;
   logic drop_q;

   assign self_hit = (bus.req_col_addr_i == SELF_COL) && (bus.req_row_addr_i == SELF_ROW);
   assign drop_o   = drop_q;
`endif

   // Header payload: zero padding above {row, col}, col in the LSBs.
   always_comb begin
      header_data = '0;
      header_data[PACKET_ADDR_COL_W-1:0] = bus.req_col_addr_i;
      header_data[PACKET_ADDR_COL_W +: PACKET_ADDR_ROW_W] = bus.req_row_addr_i;
   end

   assign out_free = !flit_valid_q || bus.flit_ready_i;

   // Next-state, handshake readies and the flit to load this cycle.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      flit_d      = flit_q;
      load_flit   = 1'b0;
      req_ready   = 1'b0;
      data_ready  = 1'b0;
      req_fire    = 1'b0;
      data_fire   = 1'b0;
`ifdef NI_SELF_ADDR_DROP_EN
      drop_fire   = 1'b0;
      drop_mode_d = drop_mode_q;
`endif
      case (state_q)
         IDLE: begin
            req_ready = out_free && !rst_i;
            req_fire  = bus.req_valid_i && req_ready;
            if (req_fire) begin
`ifdef NI_SELF_ADDR_DROP_EN
               if (self_hit) begin
                  drop_fire = 1'b1;
                  if (bus.req_len_i != '0) begin
                     state_d     = BODY;
                     remaining_d = bus.req_len_i;
                     drop_mode_d = 1'b1;
                  end
               end else
`endif
               begin
                  load_flit = 1'b1;
                  if (bus.req_len_i == '0) begin
                     flit_d = {TYPE_HEAD_TAIL, header_data};
                  end else begin
                     flit_d      = {TYPE_HEAD, header_data};
                     state_d     = BODY;
                     remaining_d = bus.req_len_i;
                  end
               end
            end
         end
         BODY: begin
`ifdef NI_SELF_ADDR_DROP_EN
            if (drop_mode_q) data_ready = !rst_i;
            else
`endif
            data_ready = out_free && !rst_i;
            data_fire  = bus.data_valid_i && data_ready;
            if (data_fire) begin
               remaining_d = remaining_q - LEN_W'(1);
`ifdef NI_SELF_ADDR_DROP_EN
               if (!drop_mode_q)
`endif
               begin
                  load_flit = 1'b1;
                  flit_d    = {(remaining_q == LEN_W'(1)) ? TYPE_TAIL : TYPE_BODY, bus.data_i};
               end
               if (remaining_q == LEN_W'(1)) begin
                  state_d = IDLE;
`ifdef NI_SELF_ADDR_DROP_EN
                  drop_mode_d = 1'b0;
`endif
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, length counter and output register; a load in the same cycle
   // as a handoff simply replaces the flit and keeps valid high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         flit_valid_q <= 1'b0;
         flit_q       <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         if (load_flit) begin
            flit_q       <= flit_d;
            flit_valid_q <= 1'b1;
         end else if (bus.flit_ready_i) begin
            flit_valid_q <= 1'b0;
         end
      end
   end

`ifdef NI_SELF_ADDR_DROP_EN
   // Tracks whether the current body is being drained silently, and
   // produces the one-cycle drop indication after a self-addressed accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         drop_mode_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         drop_mode_q <= drop_mode_d;
         drop_q      <= drop_fire;
      end
   end
`endif

   assign bus.req_ready_o  = req_ready;
   assign bus.data_ready_o = data_ready;
   assign bus.flit_valid_o = flit_valid_q;
   assign bus.flit_o       = flit_q;
   assign bus.busy_o       = (state_q != IDLE) || flit_valid_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer. Expected flits are queued as
// stimulus is applied and compared in order as the router side accepts them.
// Covers the self-address drop path when NI_SELF_ADDR_DROP_EN is defined.
`timescale 1ns/1ps
module tb_ni_packetizer;

   localparam int COL_W  = 4;
   localparam int ROW_W  = 4;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef NI_SELF_ADDR_DROP_EN
   logic dropPulse;
`endif

   ni_packetizer_if #(
      .PACKET_ADDR_COL_W(COL_W),
      .PACKET_ADDR_ROW_W(ROW_W),
      .FLIT_DATA_W(DATA_W),
      .LEN_W(LEN_W)
   ) bus ();

   ni_packetizer #(
      .COL_CORD(4'd0),
      .ROW_CORD(4'd0),
      .PACKET_ADDR_COL_W(COL_W),
      .PACKET_ADDR_ROW_W(ROW_W),
      .FLIT_DATA_W(DATA_W),
      .LEN_W(LEN_W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
`ifdef NI_SELF_ADDR_DROP_EN
      .drop_o(dropPulse),
`endif
      .bus(bus)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   int errorCount = 0;
   int checkCount = 0;
   int cycleCount = 0;
   int dropCount  = 0;
   logic [DATA_W+1:0] sbQueue[$];
   int hsCycles[$];

   // Counts rising edges so handshake timing can be compared against accepts.
   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Mid-cycle monitor: a flit seen valid with ready high is taken at the next edge.
   always @(negedge clk) begin
      if (!rst && bus.flit_valid_o && bus.flit_ready_i) begin
         hsCycles.push_back(cycleCount);
         if (sbQueue.size() == 0) checkOutput("sbUnderflow", sbQueue.size(), 1);
         else checkOutput("flit", bus.flit_o, sbQueue.pop_front());
      end
`ifdef NI_SELF_ADDR_DROP_EN
      if (!rst && dropPulse === 1'b1) dropCount++;
`endif
   end

   task automatic sendRequest(input logic [3:0] col, input logic [3:0] row, input logic [3:0] len,
                              output int acceptNeg);
      int budget = 0;
      bus.req_valid_i    = 1'b1;
      bus.req_col_addr_i = col;
      bus.req_row_addr_i = row;
      bus.req_len_i      = len;
      @(negedge clk);
      while (!bus.req_ready_o && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("reqAccepted", 32'(bus.req_ready_o), 1);
      acceptNeg = cycleCount;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
   endtask

   task automatic sendWord(input logic [DATA_W-1:0] word);
      int budget = 0;
      bus.data_valid_i = 1'b1;
      bus.data_i       = word;
      @(negedge clk);
      while (!bus.data_ready_o && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      checkOutput("wordAccepted", 32'(bus.data_ready_o), 1);
      @(posedge clk);
      #1;
      bus.data_valid_i = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] col, input logic [3:0] row, input logic [3:0] len,
                                input logic [DATA_W-1:0] base, output int acceptNeg);
      logic [DATA_W-1:0] word;
      sbQueue.push_back({(len == 0) ? 2'b11 : 2'b01, row, col});
      for (int i = 0; i < int'(len); i++) begin
         word = DATA_W'(int'(base) + i);
         sbQueue.push_back({(i == int'(len) - 1) ? 2'b10 : 2'b00, word});
      end
      sendRequest(col, row, len, acceptNeg);
      for (int i = 0; i < int'(len); i++) begin
         sendWord(DATA_W'(int'(base) + i));
      end
   endtask

   task automatic waitDrain(input string tag);
      int budget = 0;
      while (sbQueue.size() != 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      checkOutput(tag, sbQueue.size(), 0);
   endtask

   // Main sequence
   initial begin
      int acc;
      int acc2;
      bus.req_valid_i    = 1'b0;
      bus.req_col_addr_i = '0;
      bus.req_row_addr_i = '0;
      bus.req_len_i      = '0;
      bus.data_valid_i   = 1'b0;
      bus.data_i         = '0;
      bus.flit_ready_i   = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rstFlitValid", 32'(bus.flit_valid_o), 0);
      checkOutput("rstFlit", 32'(bus.flit_o), 0);
      checkOutput("rstReqReady", 32'(bus.req_ready_o), 0);
      checkOutput("rstDataReady", 32'(bus.data_ready_o), 0);
      checkOutput("rstBusy", 32'(bus.busy_o), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Payload offered in IDLE is not consumed
      bus.data_valid_i = 1'b1;
      bus.data_i       = 8'h55;
      @(negedge clk);
      checkOutput("idleDataReady", 32'(bus.data_ready_o), 0);
      checkOutput("idleReqReady", 32'(bus.req_ready_o), 1);
      @(posedge clk);
      #1;
      bus.data_valid_i = 1'b0;

      // Header-only packet
      $display("[TB] header-only packet");
      hsCycles.delete();
      applyStimulus(4'd3, 4'd2, 4'd0, 8'h00, acc);
      waitDrain("t1Drain");
      checkOutput("t1Count", hsCycles.size(), 1);
      if (hsCycles.size() >= 1) checkOutput("t1Latency", 32'(hsCycles[0] - acc), 1);
      @(negedge clk);
      checkOutput("t1BusyIdle", 32'(bus.busy_o), 0);

      // Three-word packet, no backpressure
      $display("[TB] three-word packet");
      @(posedge clk);
      #1;
      hsCycles.delete();
      applyStimulus(4'd1, 4'd4, 4'd3, 8'hA1, acc);
      waitDrain("t2Drain");
      checkOutput("t2Count", hsCycles.size(), 4);
      if (hsCycles.size() == 4) begin
         checkOutput("t2Latency", 32'(hsCycles[0] - acc), 1);
         checkOutput("t2Span", 32'(hsCycles[3] - hsCycles[0]), 3);
      end

      // Same packet with a 3-cycle router stall on the A2 flit
      $display("[TB] stall on body flit");
      @(posedge clk);
      #1;
      fork
         applyStimulus(4'd1, 4'd4, 4'd3, 8'hA1, acc);
         begin
            int budget = 0;
            do begin
               @(posedge clk);
               #1;
               budget++;
            end while (!(bus.flit_valid_o && bus.flit_o == {2'b00, 8'hA2}) && budget < 50);
            checkOutput("t3SawA2", 32'(bus.flit_o), 32'({2'b00, 8'hA2}));
            bus.flit_ready_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               checkOutput("t3Hold", 32'(bus.flit_o), 32'({2'b00, 8'hA2}));
               checkOutput("t3Valid", 32'(bus.flit_valid_o), 1);
               checkOutput("t3StallDataReady", 32'(bus.data_ready_o), 0);
            end
            @(posedge clk);
            #1;
            bus.flit_ready_i = 1'b1;
         end
      join
      waitDrain("t3Drain");

      // Back-to-back requests, no bubble
      $display("[TB] back-to-back requests");
      @(posedge clk);
      #1;
      hsCycles.delete();
      applyStimulus(4'd5, 4'd6, 4'd1, 8'hC1, acc);
      applyStimulus(4'd7, 4'd1, 4'd0, 8'h00, acc2);
      waitDrain("t4Drain");
      checkOutput("t4Count", hsCycles.size(), 3);
      if (hsCycles.size() == 3) checkOutput("t4Span", 32'(hsCycles[2] - hsCycles[0]), 2);

      // Reset in the middle of a len=5 packet with the second body flit pending
      $display("[TB] reset mid-packet");
      @(posedge clk);
      #1;
      sbQueue.push_back({2'b01, 4'd3, 4'd2});
      sbQueue.push_back({2'b00, 8'hB1});
      sendRequest(4'd2, 4'd3, 4'd5, acc);
      sendWord(8'hB1);
      sendWord(8'hB2);
      checkOutput("t5PendValid", 32'(bus.flit_valid_o), 1);
      checkOutput("t5PendBusy", 32'(bus.busy_o), 1);
      bus.flit_ready_i = 1'b0;
      rst              = 1'b1;
      bus.data_valid_i = 1'b1;
      bus.data_i       = 8'hB3;
      @(negedge clk);
      checkOutput("t5RstReqReady", 32'(bus.req_ready_o), 0);
      checkOutput("t5RstDataReady", 32'(bus.data_ready_o), 0);
      @(posedge clk);
      #1;
      rst              = 1'b0;
      bus.data_valid_i = 1'b0;
      bus.flit_ready_i = 1'b1;
      @(negedge clk);
      checkOutput("t5FlitValid", 32'(bus.flit_valid_o), 0);
      checkOutput("t5Busy", 32'(bus.busy_o), 0);
      checkOutput("t5Partial", sbQueue.size(), 0);
      @(posedge clk);
      #1;
      applyStimulus(4'd2, 4'd1, 4'd0, 8'h00, acc);
      waitDrain("t5Drain");

`ifdef NI_SELF_ADDR_DROP_EN
      // Self-addressed request is drained without emitting flits
      $display("[TB] self-address drop");
      @(posedge clk);
      #1;
      dropCount = 0;
      sendRequest(4'd0, 4'd0, 4'd2, acc);
      sendWord(8'hD1);
      sendWord(8'hD2);
      repeat (3) @(negedge clk);
      checkOutput("t6DropCount", dropCount, 1);
      checkOutput("t6FlitValid", 32'(bus.flit_valid_o), 0);
      checkOutput("t6Busy", 32'(bus.busy_o), 0);
`endif

      repeat (3) @(negedge clk);
      checkOutput("finalQueue", sbQueue.size(), 0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation timed out");
   end

endmodule
